active_block_arbiter: RTL and testbench

- Round-robin scheduler that shares the single block-transfer-to-host channel of the active block between NUM_REQ independent data sources.
- Selects one requester at a time and presents its endpoint address, length and byte stream to the active block.
- Pulses start_transfer, counts bytes accepted on transfer_ready, waits for the channel to go idle, then reports completion or timeout to that requester.
- Sits between the application data sources and the active block's start_transfer/uc_addr/uc_length/transfer_to_host inputs.

---
 rtl/active_block_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_active_block_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/active_block_arbiter.sv
// Round-robin arbiter that gives one requester at a time the active block's
// block-transfer-to-host channel. It sequences start, byte streaming, drain and completion or timeout.
module active_block_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BASE = 0,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   uc_clk,
  input  logic                   uc_reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_len,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     byte_taken,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic                   start_transfer,
  output logic [2:0]             uc_addr,
  output logic [7:0]             uc_length,
  output logic [7:0]             transfer_to_host,
  input  logic                   transfer_ready,
  input  logic                   transfer_busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDXW:0]   NUM_REQ_W = (IDXW+1)'(NUM_REQ);
  localparam logic [IDXW-1:0] PTR_INIT  = IDXW'(NUM_REQ - 1);
  localparam logic [9:0]      TMO_LAST  = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, XFER, DRAIN, FINISH} state_t;

  state_t             state_reg, state_next;
  logic [IDXW-1:0]    ptr_reg, ptr_next;
  logic [IDXW-1:0]    idx_reg, idx_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [2:0]         uc_addr_reg, uc_addr_next;
  logic [7:0]         uc_length_reg, uc_length_next;
  logic [7:0]         byte_cnt_reg, byte_cnt_next;
  logic [9:0]         tmo_cnt_reg, tmo_cnt_next;
  logic               drain_cnt_reg, drain_cnt_next;
  logic               start_reg, start_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] err_reg, err_next;

  logic [7:0] len_arr  [NUM_REQ];
  logic [7:0] data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign len_arr[gi]  = req_len[8*gi +: 8];
      assign data_arr[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Scan from the farthest candidate to the nearest so the nearest requester after ptr wins.
  logic [IDXW-1:0] sel_idx;
  logic            sel_valid;
  logic [IDXW:0]   cand;

  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr_reg} + (IDXW+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (req[cand[IDXW-1:0]]) begin
        sel_idx   = cand[IDXW-1:0];
        sel_valid = 1'b1;
      end
    end
  end

  logic [7:0] byte_inc;
  logic [9:0] tmo_inc;

  assign byte_inc = byte_cnt_reg + 8'd1;
  assign tmo_inc  = tmo_cnt_reg + 10'd1;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    idx_next       = idx_reg;
    grant_next     = grant_reg;
    uc_addr_next   = uc_addr_reg;
    uc_length_next = uc_length_reg;
    byte_cnt_next  = byte_cnt_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    start_next     = 1'b0;
    done_next      = '0;
    err_next       = '0;

    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          ptr_next            = sel_idx;
          idx_next            = sel_idx;
          grant_next          = '0;
          grant_next[sel_idx] = 1'b1;
          uc_addr_next        = 3'(ADDR_BASE) + 3'(sel_idx);
          uc_length_next      = len_arr[sel_idx];
          state_next          = (len_arr[sel_idx] == 8'd0) ? FINISH : START;
        end
      end

      START: begin
        start_next    = 1'b1;
        byte_cnt_next = '0;
        tmo_cnt_next  = '0;
        state_next    = XFER;
      end

      XFER: begin
        if (transfer_ready) begin
          byte_cnt_next = byte_inc;
          tmo_cnt_next  = '0;
          if (byte_inc == uc_length_reg) begin
            drain_cnt_next = 1'b0;
            state_next     = DRAIN;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          err_next       = grant_reg;
          grant_next     = '0;
          uc_addr_next   = '0;
          uc_length_next = '0;
          tmo_cnt_next   = '0;
          state_next     = IDLE;
        end else begin
          tmo_cnt_next = tmo_inc;
        end
      end

      // drain_cnt_reg guarantees two cycles here before busy is trusted.
      DRAIN: begin
        if (drain_cnt_reg && !transfer_busy) begin
          state_next = FINISH;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          err_next       = grant_reg;
          grant_next     = '0;
          uc_addr_next   = '0;
          uc_length_next = '0;
          tmo_cnt_next   = '0;
          state_next     = IDLE;
        end else begin
          drain_cnt_next = 1'b1;
          tmo_cnt_next   = tmo_inc;
        end
      end

      FINISH: begin
        done_next      = grant_reg;
        grant_next     = '0;
        uc_addr_next   = '0;
        uc_length_next = '0;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge uc_clk) begin
    if (!uc_reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= PTR_INIT;
      idx_reg       <= '0;
      grant_reg     <= '0;
      uc_addr_reg   <= '0;
      uc_length_reg <= '0;
      byte_cnt_reg  <= '0;
      tmo_cnt_reg   <= '0;
      drain_cnt_reg <= 1'b0;
      start_reg     <= 1'b0;
      done_reg      <= '0;
      err_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      idx_reg       <= idx_next;
      grant_reg     <= grant_next;
      uc_addr_reg   <= uc_addr_next;
      uc_length_reg <= uc_length_next;
      byte_cnt_reg  <= byte_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      start_reg     <= start_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign grant            = grant_reg;
  assign done             = done_reg;
  assign err              = err_reg;
  assign start_transfer   = start_reg;
  assign uc_addr          = uc_addr_reg;
  assign uc_length        = uc_length_reg;
  assign byte_taken       = (state_reg == XFER && transfer_ready) ? grant_reg : '0;
  assign transfer_to_host = (state_reg == XFER) ? data_arr[idx_reg] : 8'd0;

endmodule

// File: tb/tb_active_block_arbiter.sv
// Scoreboard bench for active_block_arbiter: expected grants and completions are queued
// as stimulus is issued and matched when the DUT reports them.
module tb_active_block_arbiter;

  localparam int N   = 4;
  localparam int AB  = 5;
  localparam int TMO = 40;

  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  logic           uc_clk = 1'b0;
  logic           uc_reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*8-1:0] req_len = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   grant, byte_taken, done, err;
  logic           start_transfer;
  logic [2:0]     uc_addr;
  logic [7:0]     uc_length, transfer_to_host;
  logic           transfer_ready = 1'b0;
  logic           transfer_busy = 1'b0;

  always #5 uc_clk = ~uc_clk;

  active_block_arbiter #(.NUM_REQ(N), .ADDR_BASE(AB), .TIMEOUT(TMO)) dut (
    .uc_clk(uc_clk), .uc_reset(uc_reset), .req(req), .req_len(req_len), .req_data(req_data),
    .grant(grant), .byte_taken(byte_taken), .done(done), .err(err),
    .start_transfer(start_transfer), .uc_addr(uc_addr), .uc_length(uc_length),
    .transfer_to_host(transfer_to_host), .transfer_ready(transfer_ready),
    .transfer_busy(transfer_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int kind;
    int idx;
    int len;
    int gap;
  } ev_t;

  ev_t exp_q[$];

  task automatic push_ev(input int kind, input int idx, input int len, input int gap);
    ev_t e;
    e.kind = kind; e.idx = idx; e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, tracks the current transfer.
  logic [N-1:0] prev_grant = '0;
  int  cur_idx = 0, cur_len = 0, bytes = 0, cyc_g = 0, cyc_b = 0;
  bit  in_xfer = 0;

  always @(negedge uc_clk) begin
    ev_t e;
    if (!uc_reset) begin
      prev_grant = '0;
      in_xfer = 0;
      bytes = 0;
    end else begin
      cyc_g++;
      cyc_b++;
      if (grant != 0 && prev_grant == 0) begin
        if (exp_q.size() == 0) begin
          check_eq("grant_unexpected", 32'(grant), 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("grant_kind", e.kind, K_GRANT);
          check_eq("grant", 32'(grant), 32'(1) << e.idx);
          check_eq("uc_addr", 32'(uc_addr), (AB + e.idx) % 8);
          check_eq("uc_length", 32'(uc_length), e.len);
          cur_idx = e.idx;
          cur_len = e.len;
        end
        cyc_g = 0;
        bytes = 0;
        in_xfer = 0;
      end
      if (start_transfer) begin
        check_eq("start_latency", cyc_g, 1);
        check_eq("start_len_nonzero", 32'(cur_len != 0), 1);
        in_xfer = 1;
      end
      if (byte_taken != 0 || (in_xfer && transfer_ready)) begin
        check_eq("byte_window", 32'(in_xfer), 1);
        check_eq("byte_taken", 32'(byte_taken), 32'(1) << cur_idx);
        check_eq("transfer_to_host", 32'(transfer_to_host), 32'(req_data[8*cur_idx +: 8]));
        bytes++;
        cyc_b = 0;
        if (bytes >= cur_len) in_xfer = 0;
      end
      if (done != 0 || err != 0) begin
        check_eq("done_err_exclusive", 32'((done != 0) && (err != 0)), 0);
        if (exp_q.size() == 0) begin
          check_eq("event_unexpected", 32'({done, err}), 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("event_kind", 32'(e.kind == K_GRANT), 0);
          if (e.kind == K_DONE) begin
            check_eq("done", 32'(done), 32'(1) << e.idx);
            check_eq("bytes_at_done", bytes, cur_len);
            if (e.gap >= 0) check_eq("done_latency", cyc_g, e.gap);
          end else begin
            check_eq("err", 32'(err), 32'(1) << e.idx);
            if (e.gap >= 0) check_eq("err_latency", cyc_b, e.gap);
          end
          check_eq("grant_cleared", 32'(grant), 0);
        end
        $display("txn req %0d len %0d bytes %0d %s", cur_idx, cur_len, bytes,
                 (done != 0) ? "done" : "err");
        in_xfer = 0;
      end
      prev_grant = grant;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge uc_clk);
    #1;
  endtask

  // what: 0 grant, 1 start_transfer, 2 done or err
  task automatic wait_for(input int what, input int limit, input string tag);
    bit hit;
    hit = 0;
    for (int c = 0; c < limit && !hit; c++) begin
      @(negedge uc_clk);
      case (what)
        0:       hit = (grant != 0);
        1:       hit = start_transfer;
        default: hit = (done != 0) || (err != 0);
      endcase
    end
    if (!hit) check_eq({tag, "_wait_expired"}, 0, 1);
  endtask

  task automatic give_bytes(input int idx, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      req_data[8*idx +: 8] = 8'($urandom);
      transfer_ready = 1'b1;
      tick();
      transfer_ready = 1'b0;
      if (gap > 0) tick(gap);
    end
  endtask

  task automatic serve(input int idx, input int n, input int gap, input bit drop);
    wait_for(1, 12, "start");
    if (drop) req[idx] = 1'b0;
    transfer_busy = 1'b1;
    tick();
    give_bytes(idx, n, gap);
    tick(2);
    transfer_busy = 1'b0;
    wait_for(2, 20, "done");
  endtask

  task automatic apply_reset();
    uc_reset = 1'b0;
    tick(2);
    uc_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state with a stray ready strobe.
    transfer_ready = 1'b1;
    tick(3);
    @(negedge uc_clk);
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_byte_taken", 32'(byte_taken), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_start", 32'(start_transfer), 0);
    check_eq("rst_addr", 32'(uc_addr), 0);
    check_eq("rst_length", 32'(uc_length), 0);
    check_eq("rst_tth", 32'(transfer_to_host), 0);
    transfer_ready = 1'b0;
    uc_reset = 1'b1;
    tick();

    // Single requester, 3 bytes with gaps.
    push_ev(K_GRANT, 0, 3, -1);
    push_ev(K_DONE, 0, 3, -1);
    req_len[7:0] = 8'd3;
    req[0] = 1'b1;
    serve(0, 3, 1, 1);
    tick(2);

    // Continuous requests, all lengths 1: order 0,1,2,3,0 from a fresh reset.
    apply_reset();
    for (int i = 0; i < N; i++) req_len[8*i +: 8] = 8'd1;
    for (int t = 0; t < 5; t++) begin
      push_ev(K_GRANT, t % N, 1, -1);
      push_ev(K_DONE, t % N, 1, -1);
    end
    req = 4'b1111;
    for (int t = 0; t < 4; t++) serve(t, 1, 0, 0);
    req = 4'b0001;
    serve(0, 1, 0, 1);
    tick(2);

    // Zero-length request: no start, done one cycle after grant.
    push_ev(K_GRANT, 2, 0, -1);
    push_ev(K_DONE, 2, 0, 1);
    req_len[23:16] = 8'd0;
    req[2] = 1'b1;
    wait_for(0, 10, "grant_zero_len");
    req[2] = 1'b0;
    wait_for(2, 10, "done_zero_len");
    tick(2);

    // Timeout after 2 of 4 bytes, then the next requester is served.
    push_ev(K_GRANT, 3, 4, -1);
    push_ev(K_ERR, 3, 4, TMO + 1);
    push_ev(K_GRANT, 1, 1, -1);
    push_ev(K_DONE, 1, 1, -1);
    req_len[31:24] = 8'd4;
    req_len[15:8]  = 8'd1;
    req[3] = 1'b1;
    req[1] = 1'b1;
    wait_for(1, 12, "start_tmo");
    req[3] = 1'b0;
    transfer_busy = 1'b1;
    tick();
    give_bytes(3, 2, 0);
    wait_for(2, TMO + 20, "err_tmo");
    transfer_busy = 1'b0;
    serve(1, 1, 0, 1);
    tick(2);

    // Reset during byte 2 of 5, then priority restarts at requester 0.
    push_ev(K_GRANT, 2, 5, -1);
    req_len[23:16] = 8'd5;
    req[2] = 1'b1;
    wait_for(1, 12, "start_mid_reset");
    req[2] = 1'b0;
    transfer_busy = 1'b1;
    tick();
    give_bytes(2, 2, 0);
    uc_reset = 1'b0;
    transfer_busy = 1'b0;
    tick();
    uc_reset = 1'b1;
    @(negedge uc_clk);
    check_eq("midrst_grant", 32'(grant), 0);
    check_eq("midrst_start", 32'(start_transfer), 0);
    check_eq("midrst_addr", 32'(uc_addr), 0);
    check_eq("midrst_length", 32'(uc_length), 0);
    check_eq("midrst_tth", 32'(transfer_to_host), 0);
    check_eq("midrst_done_err", 32'({done, err}), 0);
    tick(3);
    check_eq("midrst_pending", exp_q.size(), 0);
    push_ev(K_GRANT, 0, 1, -1);
    push_ev(K_DONE, 0, 1, -1);
    push_ev(K_GRANT, 3, 1, -1);
    push_ev(K_DONE, 3, 1, -1);
    req_len[7:0]   = 8'd1;
    req_len[31:24] = 8'd1;
    req = 4'b1001;
    serve(0, 1, 0, 1);
    serve(3, 1, 0, 1);
    tick(2);

    // Ready held high through IDLE and DRAIN; req[1] dropped mid-transfer.
    push_ev(K_GRANT, 1, 3, -1);
    push_ev(K_DONE, 1, 3, -1);
    req_len[15:8] = 8'd3;
    transfer_ready = 1'b1;
    tick(2);
    req[1] = 1'b1;
    wait_for(1, 12, "start_ready_high");
    req[1] = 1'b0;
    transfer_busy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      req_data[15:8] = 8'($urandom);
    end
    transfer_busy = 1'b0;
    wait_for(2, 20, "done_ready_high");
    tick(3);
    transfer_ready = 1'b0;
    tick(2);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
